// File: rtl/rx_comb_decimation.sv
// Polyphase decimate-by-4 FIR for the Rx path: 16-tap delay line, parallel
// constant multipliers and a 3-stage adder pipeline, one output per 4 inputs.

module rx_comb_tap #(
    parameter int                 IN_W = 11,
    parameter logic signed [IN_W-1:0] COEF = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic signed [IN_W-1:0]   x,
    output logic signed [2*IN_W-1:0] p
);
    localparam int PROD_W = 2 * IN_W;
    localparam logic signed [IN_W-1:0] C = COEF;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  p <= '0;
        else if (en) p <= PROD_W'(x) * PROD_W'(C);
    end
endmodule

module rx_comb_decimation #(
    parameter int IN_W  = 11,
    parameter int OUT_W = 23,
    parameter logic [16*IN_W-1:0] COEFFS = {11'sd4, 11'sd20, 11'sd52, 11'sd100,
                                            11'sd156, 11'sd204, 11'sd244, 11'sd284,
                                            11'sd284, 11'sd244, 11'sd204, 11'sd156,
                                            11'sd100, 11'sd52, 11'sd20, 11'sd4}
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [IN_W-1:0]  in_comb,
    input  logic                    in_valid,
    input  logic                    ph_clr,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    out_valid
);
    localparam int NTAP   = 16;
    localparam int NBR    = 4;
    localparam int PROD_W = 2 * IN_W;
    localparam int BR_W   = PROD_W + 2;
    localparam int SUM_W  = BR_W + 2;
    localparam int STAGES = 4;

    logic [NTAP-1:0][IN_W-1:0]   taps;
    logic [NTAP-1:0][PROD_W-1:0] prod;
    logic [NBR-1:0][BR_W-1:0]    br, br_nx;
    logic [SUM_W-1:0]            sum;
    logic [1:0]                  phase;
    logic                        launch;
    // [1] launched, [2] products valid, [3] branch sums valid, [4] output pulse
    logic [STAGES:1]             vld_pipe;

    assign launch    = in_valid && !ph_clr && (phase == 2'd3);
    assign out_valid = vld_pipe[STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taps     <= '0;
            phase    <= '0;
            vld_pipe <= '0;
        end else if (ph_clr) begin
            taps     <= '0;
            phase    <= '0;
            vld_pipe <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:1], launch};
            if (in_valid) begin
                taps  <= {taps[NTAP-2:0], in_comb};
                phase <= phase + 2'd1;
            end
        end
    end

    // h[0] sits in the MSBs of COEFFS and multiplies the newest sample
    for (genvar k = 0; k < NTAP; k++) begin : g_tap
        rx_comb_tap #(
            .IN_W (IN_W),
            .COEF (COEFFS[(NTAP-1-k)*IN_W +: IN_W])
        ) u_tap (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (vld_pipe[1]),
            .x     (taps[k]),
            .p     (prod[k])
        );
    end

    always_comb begin
        br_nx = '0;
        for (int b = 0; b < NBR; b++) begin
            br_nx[b] = BR_W'($signed(prod[4*b]))   + BR_W'($signed(prod[4*b+1]))
                     + BR_W'($signed(prod[4*b+2])) + BR_W'($signed(prod[4*b+3]));
        end
    end

    always_comb begin
        sum = '0;
        for (int b = 0; b < NBR; b++) sum = sum + SUM_W'($signed(br[b]));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br       <= '0;
            out_data <= '0;
        end else begin
            if (vld_pipe[2])            br       <= br_nx;
            if (vld_pipe[3] && !ph_clr) out_data <= sum[OUT_W-1:0];
        end
    end
endmodule

// File: tb/tb_rx_comb_decimation.sv
// Scoreboard bench for rx_comb_decimation: the driver pushes expected outputs
// with their due cycle, a negedge monitor pops and compares on out_valid.

module tb_rx_comb_decimation;
    logic               clk = 1'b0;
    logic               rst_n;
    logic signed [10:0] in_comb;
    logic               in_valid;
    logic               ph_clr;
    logic signed [22:0] out_data;
    logic               out_valid;

    typedef struct { int data; int due; } exp_t;
    exp_t sb[$];
    int   hand_q[$];
    int   hist[16];
    int   h[16] = '{4, 20, 52, 100, 156, 204, 244, 284, 284, 244, 204, 156, 100, 52, 20, 4};
    int   phase = 0;
    bit   use_model = 1'b0;
    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;

    rx_comb_decimation dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_comb   (in_comb),
        .in_valid  (in_valid),
        .ph_clr    (ph_clr),
        .out_data  (out_data),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            compared++;
            if (sb.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_out: cycle %0d data %0d, no output expected", cyc, int'(out_data));
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (int'(out_data) !== e.data || cyc != e.due) begin
                    mismatched++;
                    $display("FAIL out_data: got %0d at cycle %0d, expected %0d at cycle %0d",
                             int'(out_data), cyc, e.data, e.due);
                end
            end
        end
    end

    function automatic int model_y();
        int acc = 0;
        for (int k = 0; k < 16; k++) acc += h[k] * hist[k];
        return acc;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 16; k++) hist[k] = 0;
        phase = 0;
    endtask

    task automatic send(input int v, input bit vld, input bit clr);
        exp_t e;
        @(negedge clk);
        in_comb  = 11'(v);
        in_valid = vld;
        ph_clr   = clr;
        @(posedge clk);
        #1;
        if (clr) begin
            model_clear();
            while (sb.size() > 0 && sb[$].due >= cyc) void'(sb.pop_back());
        end else if (vld) begin
            for (int k = 15; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = v;
            if (phase == 3) begin
                e.due = cyc + 3;
                if (use_model) e.data = model_y();
                else if (hand_q.size() > 0) e.data = hand_q.pop_front();
                else begin
                    e.data = 0;
                    compared++;
                    mismatched++;
                    $display("FAIL hand_table: trigger at cycle %0d had no expected value", cyc);
                end
                sb.push_back(e);
            end
            phase = (phase + 1) % 4;
        end
        in_valid = 1'b0;
        ph_clr   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) send(0, 1'b0, 1'b0);
    endtask

    task automatic impulse(input int gap);
        send(0, 1'b0, 1'b1);
        hand_q = '{100, 284, 156, 4, 0};
        for (int i = 0; i < 20; i++) begin
            send((i == 0) ? 1 : 0, 1'b1, 1'b0);
            idle(gap);
        end
        idle(5);
    endtask

    task automatic dc(input int v, input int y3, input int y7, input int y11, input int yss);
        send(0, 1'b0, 1'b1);
        hand_q = '{y3, y7, y11, yss, yss};
        repeat (20) send(v, 1'b1, 1'b0);
        idle(5);
    endtask

    task automatic check_quiet(input string name);
        compared++;
        if (out_valid !== 1'b0 || out_data !== 23'sd0) begin
            mismatched++;
            $display("FAIL %s: out_valid=%b out_data=%0d, expected 0/0", name, out_valid, int'(out_data));
        end
    endtask

    initial begin
        rst_n = 1'b0; in_comb = '0; in_valid = 1'b0; ph_clr = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk) check_quiet("reset_state");
        rst_n = 1'b1;

        // impulse, continuous then gapped
        impulse(0);
        impulse(2);

        // DC extremes, partial sums while the line fills
        dc(1023, 180048, 1088472, 1996896, 2176944);
        dc(-1024, -180224, -1089536, -1998848, -2179072);

        // ph_clr with in_valid at n=2 drops that sample and restarts phase
        send(0, 1'b0, 1'b1);
        hand_q = '{176};
        send(1, 1'b1, 1'b0);
        send(0, 1'b1, 1'b0);
        send(7, 1'b1, 1'b1);
        repeat (4) send(1, 1'b1, 1'b0);
        idle(5);

        // reset one clock after a trigger squashes the result
        send(0, 1'b0, 1'b1);
        hand_q = '{100};
        send(1, 1'b1, 1'b0);
        repeat (3) send(0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        sb.delete();
        model_clear();
        repeat (3) @(negedge clk) check_quiet("reset_mid_flight");
        rst_n = 1'b1;
        idle(2);
        impulse(0);

        // alternating extremes against the reference model
        send(0, 1'b0, 1'b1);
        use_model = 1'b1;
        for (int i = 0; i < 256; i++) send((i % 2 == 0) ? 1023 : -1024, 1'b1, 1'b0);
        idle(6);
        use_model = 1'b0;

        compared++;
        if (sb.size() != 0 || hand_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: %0d outputs still pending, %0d table entries unused, expected 0/0",
                     sb.size(), hand_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/rx_comb_decimation.md
Name: rx_comb_decimation

Overview:
Receive-side polyphase decimation-by-4 FIR. It is the counterpart of the Tx comb interpolation branches.
- Accepts 11-bit signed samples at the full rate, qualified by a valid strobe.
- Keeps a 16-deep delay line and computes one full-precision filtered output for every 4 accepted samples.
- Sits between the Rx sample front end and downstream baseband processing.
- Fully parallel constant multipliers feed a 3-stage pipelined adder tree, so it sustains one input per clock.

Parameters:
- COEFFS, default {11'sd4,11'sd20,11'sd52,11'sd100,11'sd156,11'sd204,11'sd244,11'sd284,11'sd284,11'sd244,11'sd204,11'sd156,11'sd100,11'sd52,11'sd20,11'sd4}: 176-bit packed signed taps. h[0] is in the MSBs, h[15] in the LSBs. Sum of taps is 2128.
- IN_W, default 11: input sample width (signed).
- OUT_W, default 23: output width (signed, full precision, no rounding or saturation).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_comb  in  IN_W  signed input sample.
- in_valid  in  1  sample strobe; in_comb is accepted on any rising edge where in_valid=1.
- ph_clr  in  1  synchronous clear of phase counter, delay line and pipeline valids.
- out_data  out  OUT_W  signed decimated output, registered.
- out_valid  out  1  one-cycle pulse qualifying out_data.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - out_data=0, out_valid=0.
  - Phase counter=0, all 16 delay taps=0, all pipeline registers and valids=0.
- Accepted sample index n counts accepted samples since reset or ph_clr, starting at 0.
- On acceptance:
  - The delay line shifts: x[n] enters tap 0, tap k moves to tap k+1, tap 15 is discarded.
  - A 2-bit phase counter increments and wraps 3->0.
  - Cycles with in_valid=0 leave the delay line and phase counter unchanged.
- Trigger: the acceptance with phase==3 (n = 3, 7, 11, ...) launches a computation on the updated delay line.
- Computation: y[n] = sum over k=0..15 of h[k]*x[n-k], with x[m]=0 for m<0.
- Pipeline, with the launch edge defined as E:
  - Stage 1 (edge E+1): 16 products of 11x11 bits, each 22-bit signed.
  - Stage 2 (edge E+2): 4 branch sums over taps {0-3}, {4-7}, {8-11}, {12-15}, each 24-bit signed.
  - Stage 3 (edge E+3): final sum written to out_data; out_valid=1 for that single cycle.
- Latency and hold:
  - Latency is exactly 3 clocks from the triggering acceptance edge, independent of in_valid during flight.
  - out_data holds its value between pulses.
- Throughput: in_valid may stay high every cycle, giving one output per 4 clocks. The pipeline never stalls, and there is no backpressure.
- Width: worst case is |-1024*2128| = 2,179,072, which fits 23-bit signed. The sum is sign-extended exactly, with no truncation.
- ph_clr=1 at an edge:
  - Clears the phase counter and all delay taps.
  - Clears stage valids, so any in-flight result is squashed and out_valid stays 0.
  - out_data retains its previous value.
  - Takes priority over a simultaneous in_valid; that sample is dropped.
- Reset asserted mid-computation: all state clears immediately, and no out_valid pulse emerges after release.
- Phase counter wrap: the trigger recurs every 4 accepted samples indefinitely, with no drift.

Test Plan:
1. Impulse, in_valid continuous: in_comb=1 at n=0, then 0 -> out_valid pulses at n=3,7,11,15 with out_data=100,284,156,4, then 0 thereafter. Each pulse arrives 3 clocks after the triggering edge.
2. DC extremes: 20 samples of +1023 -> 5th output onward =2,176,944. 20 samples of -1024 -> -2,179,072, with no wrap.
3. Gapped in_valid (1 of every 3 cycles), same impulse -> identical value sequence 100,284,156,4. Each out_valid occurs 3 clocks after the accepted 4th, 8th, ... sample.
4. ph_clr asserted together with in_valid at n=2 after an impulse at n=0 -> sample dropped, no output. The next 4 samples of value 1 give out_data=4+20+52+100=176 after the 4th.
5. rst_n pulled low 1 clock after a trigger -> out_valid never pulses, out_data=0. After release, the impulse test reproduces scenario 1 exactly.
6. Alternating +1023/-1024 at full rate -> steady-state outputs match a bit-exact reference model over 64 outputs.
